// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin owner of the single memory port for fetch (0), load/store (1) and DMA/debug (2).
// Latency: grant 1 cycle after request is sampled, ack at earliest 3 cycles; one IDLE cycle between accesses.
// Backpressure: requests are level-held until ack; memory stalls the owner by holding mem_mfc low.
// Optional build macro MEM_ARB_TIMEOUT_EN bounds ACCESS to TIMEOUT cycles and flags expiry on err.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [2:0]          req_rw,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          ack,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_mfc,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        ptr;        // highest-priority requester for the next arbitration
  logic [1:0]        owner;      // requester holding the port
  logic [1:0]        win;
  logic              win_vld;
  logic [1:0]        cand0, cand1, cand2;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              to_hit;     // ACCESS has run its full timeout budget this cycle
  logic              err_q;

  // Requester indices wrap 2 -> 0.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Rotating-priority search starting at ptr.
  always_comb begin
    cand0   = ptr;
    cand1   = inc3(ptr);
    cand2   = inc3(cand1);
    win     = ptr;
    win_vld = |req;
    if (req[cand0])      win = cand0;
    else if (req[cand1]) win = cand1;
    else if (req[cand2]) win = cand2;
  end

  // Mux the winner's request fields out of the packed buses.
  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (win == 2'(i)) begin
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] to_cnt;

  // Counts ACCESS cycles; held at zero elsewhere so every ACCESS entry starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     to_cnt <= '0;
    else if (state == S_ACCESS)  to_cnt <= to_cnt + 1'b1;
    else                         to_cnt <= '0;
  end

  assign to_hit = (state == S_ACCESS) && (to_cnt == CNT_W'(TIMEOUT - 1));
`else
  // Without the counter ACCESS waits for mem_mfc indefinitely.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT >= 2);
  assign to_hit         = 1'b0;
`endif

  // State register; async reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; mem_mfc only matters in ACCESS, and it beats a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (win_vld) state_nxt = S_GRANT;
      S_GRANT:  state_nxt = S_ACCESS;
      S_ACCESS: if (mem_mfc || to_hit) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Transaction registers: latch the winner in IDLE, capture read data on MFC, rotate on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 2'd0;
      owner     <= 2'd0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            owner     <= win;
            mem_rw    <= sel_rw;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        S_ACCESS: begin
          if (mem_mfc && mem_rw) rdata <= mem_rdata;
          // Only set on the cycle ACCESS is left by expiry; a late MFC wins.
          err_q <= !mem_mfc && to_hit;
        end
        S_DONE: begin
          ptr   <= inc3(owner);
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the state and owner registers.
  assign busy   = (state != S_IDLE);
  assign mem_en = (state == S_ACCESS);
  assign gnt    = busy ? (3'b001 << owner) : 3'b000;
  assign ack    = (state == S_DONE) ? (3'b001 << owner) : 3'b000;
  assign err    = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req = '0;
  logic [2:0]    req_rw = '0;
  logic [3*AW-1:0] req_addr = '0;
  logic [3*DW-1:0] req_wdata = '0;
  logic [2:0]    gnt, ack;
  logic          err, busy, mem_en, mem_rw;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_mfc = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .busy(busy), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mfc(mem_mfc), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction record (owner, latched fields, cycles owned).
  int            m_owner = -1;  // -1 when the port is free
  int            m_age   = 0;   // 0 = setup cycle, n = n-th access cycle
  int            m_ptr   = 0;
  bit            m_fin   = 0;   // completion (ack) cycle
  bit            m_err   = 0;
  logic          m_rw    = 0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_fin = 0; m_err = 0;
      m_rw = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 3; k++) begin
        int c = (m_ptr + k) % 3;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_rw    = req_rw[c];
          m_addr  = req_addr[c*AW +: AW];
          m_wdata = req_wdata[c*DW +: DW];
          m_age   = 0;
        end
      end
    end else if (m_fin) begin
      m_ptr = (m_owner + 1) % 3;
      m_owner = -1; m_fin = 0; m_err = 0;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (mem_mfc) begin
      m_fin = 1;
      if (m_rw) m_rdata = mem_rdata;
    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
      if (m_age == TO) begin m_fin = 1; m_err = 1; end
      else m_age++;
`else
      m_age++;
`endif
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic compare_cycle();
    logic [2:0] eg;
    logic eb;
    eb = (m_owner >= 0);
    eg = eb ? (3'b001 << m_owner) : 3'b000;
    chk("busy", busy, eb);
    chk("gnt", gnt, eg);
    chk("mem_en", mem_en, eb && m_age >= 1 && !m_fin);
    chk("ack", ack, m_fin ? eg : 3'b000);
    chk("err", err, m_fin && m_err);
    chk("mem_rw", mem_rw, m_rw);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("rdata", rdata, m_rdata);
  endtask

  initial forever begin
    @(negedge clk);
    compare_cycle();
  end

  task automatic set_req(input int n, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[n] = 1'b1;
    req_rw[n] = rw;
    req_addr[n*AW +: AW] = a;
    req_wdata[n*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Serve every pending request with immediate MFC, dropping each req at its ack.
  task automatic drain(input int budget);
    int t = 0;
    mem_mfc = 1'b1;
    while ((req != 0 || busy) && t < budget) begin
      @(negedge clk);
      t++;
      for (int n = 0; n < 3; n++) if (ack[n]) req[n] = 1'b0;
    end
    chk("drain_done", (t >= budget), 0);
    mem_mfc = 1'b0;
  endtask

  int waited[3];

  initial begin
    int n_cyc, en_cnt, ack_cnt, t, bad;
    bit got;
    logic [2:0] ack_seen;
    logic err_seen;
    int order[$];

    // Reset state
    do_reset();
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);

    // Single read with MFC on the first access cycle
    mem_mfc = 1'b1;
    mem_rdata = 16'hBEEF;
    set_req(0, 1'b1, 16'h0040, 16'h0000);
    n_cyc = 0; got = 0;
    while (!got && n_cyc < 10) begin
      @(negedge clk); n_cyc++;
      if (ack != 0) begin
        got = 1;
        chk("read_ack", ack, 3'b001);
        chk("read_rdata", rdata, 16'hBEEF);
        chk("read_mem_rw", mem_rw, 1);
        chk("read_mem_addr", mem_addr, 16'h0040);
        req[0] = 1'b0;
      end
    end
    chk("read_latency", n_cyc, 3);
    mem_mfc = 1'b0;
    mem_rdata = 16'h5A5A;
    repeat (2) @(negedge clk);

    // Write with three wait states; requester scrambles its fields after GRANT
    set_req(1, 1'b0, 16'h0012, 16'h1234);
    en_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt == 3'b010 && !mem_en && ack == 0) begin
        req_addr[1*AW +: AW] = 16'hFFFF;
        req_wdata[1*DW +: DW] = 16'h0000;
      end
      if (mem_en) begin
        en_cnt++;
        chk("write_addr_stable", mem_addr, 16'h0012);
        chk("write_wdata_stable", mem_wdata, 16'h1234);
        if (en_cnt == 4) mem_mfc = 1'b1;
      end
      if (ack != 0) begin
        ack_cnt++;
        chk("write_ack", ack, 3'b010);
        req[1] = 1'b0;
        mem_mfc = 1'b0;
      end
    end
    chk("write_en_cycles", en_cnt, 4);
    chk("write_ack_count", ack_cnt, 1);
    chk("write_rdata_kept", rdata, 16'hBEEF);

    // Contention from ptr=0 with all three held
    do_reset();
    for (int n = 0; n < 3; n++) set_req(n, 1'b1, AW'(16'h0100 + n), 16'h0000);
    mem_mfc = 1'b1;
    t = 0;
    while (order.size() < 6 && t < 80) begin
      @(negedge clk); t++;
      for (int n = 0; n < 3; n++) if (ack[n]) order.push_back(n);
    end
    req = 3'b000;
    chk("contention_count", order.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("grant_order", (i < order.size()) ? order[i] : 99, i % 3);
    drain(40);

    // Async reset in ACCESS, then re-arbitration from ptr=0
    mem_mfc = 1'b0;
    set_req(0, 1'b1, 16'h0200, 16'h0000);
    t = 0;
    while (!mem_en && t < 10) begin @(negedge clk); t++; end
    chk("rstmid_reach_access", mem_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_mem_en", mem_en, 0);
    chk("rstmid_gnt", gnt, 3'b000);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ack", ack, 3'b000);
    req = 3'b000;
    set_req(1, 1'b1, 16'h0301, 16'h0000);
    set_req(2, 1'b1, 16'h0302, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (gnt == 0 && t < 10) begin @(negedge clk); t++; end
    chk("rstmid_first_gnt", gnt, 3'b010);
    drain(40);

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: MFC never comes; requesters 0 and 1 queue up meanwhile
    mem_mfc = 1'b0;
    set_req(2, 1'b1, 16'h0222, 16'h0000);
    en_cnt = 0; t = 0; got = 0; ack_seen = '0; err_seen = 0;
    while (!got && t < 40) begin
      @(negedge clk); t++;
      if (mem_en) begin
        en_cnt++;
        if (!req[0]) begin
          set_req(0, 1'b1, 16'h0010, 16'h0000);
          set_req(1, 1'b1, 16'h0011, 16'h0000);
        end
      end
      if (ack != 0) begin got = 1; ack_seen = ack; err_seen = err; req[2] = 1'b0; end
    end
    chk("to_en_cycles", en_cnt, TO);
    chk("to_ack", ack_seen, 3'b100);
    chk("to_err", err_seen, 1);
    t = 0;
    while (gnt == 0 && t < 10) begin @(negedge clk); t++; end
    chk("to_next_gnt", gnt, 3'b001);
    drain(60);
`else
    // No timeout: ACCESS holds indefinitely until MFC
    mem_mfc = 1'b0;
    set_req(2, 1'b1, 16'h0222, 16'h0000);
    t = 0;
    while (!mem_en && t < 10) begin @(negedge clk); t++; end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!mem_en || ack != 0 || err) bad++;
    end
    chk("hang_bad_cycles", bad, 0);
    mem_mfc = 1'b1;
    @(negedge clk);
    chk("hang_ack", ack, 3'b100);
    chk("hang_err", err, 0);
    req[2] = 1'b0;
    drain(20);
`endif

    // Randomized traffic against the model, with a fairness bound
    for (int n = 0; n < 3; n++) waited[n] = 0;
    for (int cy = 0; cy < 1500; cy++) begin
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        if (m_fin && m_owner == n) begin
          if (req[n]) chk("fair_wait", (waited[n] > 2), 0);
          waited[n] = 0;
          if ($urandom_range(1, 0) == 1)
            set_req(n, 1'($urandom_range(1, 0)), AW'($urandom), DW'($urandom));
          else
            req[n] = 1'b0;
        end else if (m_fin && req[n]) begin
          waited[n]++;
        end else if (!req[n] && $urandom_range(3, 0) == 0) begin
          set_req(n, 1'($urandom_range(1, 0)), AW'($urandom), DW'($urandom));
          waited[n] = 0;
        end else if (req[n] && m_owner == n && !m_fin && m_age >= 1 && $urandom_range(63, 0) == 0) begin
          req[n] = 1'b0;
        end
      end
      mem_mfc = ($urandom_range(2, 0) == 0);
      mem_rdata = DW'($urandom);
    end
    req = 3'b000;
    drain(60);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
